stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of stack data words.
REQ-002 SHALL have parameter DEPTH, default 64, meaning number of stack entries.
REQ-003 SHALL have parameter CNT_W, default 7, meaning occupancy counter width (holds 0..DEPTH).
REQ-004 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  1  client request present.
REQ-007 SHALL have port req_op  in  1  0 = push, 1 = pop.
REQ-008 SHALL have port req_data  in  DATA_W  push data.
REQ-009 SHALL have port req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-010 SHALL have port rsp_valid  out  1  pop response available.
REQ-011 SHALL have port rsp_ready  in  1  client consumes response.
REQ-012 SHALL have port rsp_data  out  DATA_W  popped word.
REQ-013 SHALL have port rsp_err  out  1  response belongs to an underflowed pop.
REQ-014 SHALL have port flush  in  1  empty the stack (SP := 0).
REQ-015 SHALL have port clr_err  in  1  clear sticky error flags.
REQ-016 SHALL have port full, empty  out  1 each  occupancy == DEPTH / == 0.
REQ-017 SHALL have port err_overflow, err_underflow  out  1 each  sticky error flags.
REQ-018 SHALL have port stk_push_enable, stk_pop_enable, stk_read_enable  out  1 each  stack RAM controls.
REQ-019 SHALL have port stk_sp_in, stk_data_in  out  32, DATA_W  stack pointer and write data to the stack RAM.
REQ-020 SHALL have port stk_data_out  in  DATA_W  stack RAM read data, valid one cycle after stk_pop_enable.

Function
REQ-021 SHALL own the stack pointer sp (CNT_W bits) and drive stk_sp_in = sp zero-extended to 32 bits.
REQ-022 SHALL implement FSM states IDLE, POP_WAIT, RESP.
REQ-023 SHALL assert req_ready only in IDLE with flush low.
REQ-024 Push accepted with sp < DEPTH SHALL drive stk_push_enable = 1 and stk_data_in = req_data combinationally in the accept cycle, with sp := sp+1 at the next edge; FSM stays in IDLE.
REQ-025 Push accepted with sp == DEPTH SHALL be consumed without asserting stk_push_enable, leave sp unchanged, and set err_overflow.
REQ-026 Pop accepted with sp > 0 SHALL drive stk_pop_enable = 1 in the accept cycle, set sp := sp-1, and enter POP_WAIT.
REQ-027 In POP_WAIT the block SHALL capture stk_data_out into rsp_data with rsp_err = 0 and enter RESP.
REQ-028 Pop accepted with sp == 0 SHALL skip the RAM, load rsp_data = 0 with rsp_err = 1, set err_underflow, and enter RESP directly.
REQ-029 In RESP the block SHALL hold rsp_valid = 1 with rsp_data stable until rsp_ready, then return to IDLE.
REQ-030 Pop latency SHALL be 2 cycles from accept to rsp_valid (1 cycle on underflow).
REQ-031 flush in IDLE SHALL set sp := 0 and override a simultaneous request, which is not accepted; flush in POP_WAIT or RESP SHALL be ignored.
REQ-032 Sticky errors SHALL clear on clr_err; if a new error and clr_err occur in the same cycle, the flag SHALL end set.
REQ-033 stk_read_enable SHALL be tied to 0.
REQ-034 stk_push_enable and stk_pop_enable SHALL never be asserted in the same cycle.

Reset
REQ-035 reset SHALL force: sp = 0, state = IDLE, rsp_valid = 0, rsp_data = 0, rsp_err = 0, err_overflow = 0, err_underflow = 0, stk_* enables = 0.
REQ-036 reset in POP_WAIT or RESP SHALL discard the pending response.

Structure
REQ-037 A shared package stack_pkg SHALL hold DATA_W, DEPTH, the CNT_W constant, the push/pop op encoding and the FSM state enum.
REQ-038 The block SHALL contain no sub-module and sit upstream of the stack RAM as a peer instance; its stk_* ports SHALL connect directly to the RAM's ports.

Verification
REQ-039 Push 0xA, 0xB, 0xC, then pop x3 -> rsp_data 0xC, 0xB, 0xA, each 2 cycles after accept; final sp = 0 and empty = 1.
REQ-040 Push 64 words, then push 0xDEAD -> full = 1, err_overflow = 1, no stk_push_enable on the 65th push, sp = 64.
REQ-041 Pop on empty -> rsp_valid next cycle with rsp_data = 0 and rsp_err = 1, err_underflow = 1; then clr_err -> flag = 0.
REQ-042 Hold rsp_ready low for 5 cycles -> rsp_valid and rsp_data stable and req_ready = 0 throughout.
REQ-043 Push x3, then flush together with push request -> request not accepted and sp = 0 next cycle.
REQ-044 Reset asserted in POP_WAIT -> next cycle state IDLE, rsp_valid = 0 and sp = 0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants for the stack controller: default geometry, op encoding and FSM states.
package stack_pkg;

    localparam int unsigned STACK_DATA_W = 32;
    localparam int unsigned STACK_DEPTH  = 64;
    localparam int unsigned STACK_CNT_W  = 7;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPopWait = 2'd1;
    localparam logic [1:0] StResp    = 2'd2;

endpackage

// File: rtl/stack_ctrl.sv
// Stack controller: owns the stack pointer, sequences push/pop requests against an external
// stack RAM and returns popped words through a valid/ready response channel.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W = STACK_DATA_W,
    parameter int unsigned DEPTH  = STACK_DEPTH,
    parameter int unsigned CNT_W  = STACK_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              flush,
    input  logic              clr_err,
    output logic              full,
    output logic              empty,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic              stk_push_enable,
    output logic              stk_pop_enable,
    output logic              stk_read_enable,
    output logic [31:0]       stk_sp_in,
    output logic [DATA_W-1:0] stk_data_in,
    input  logic [DATA_W-1:0] stk_data_out
);

    localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] OneC   = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  sp_q, sp_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ovf_set, unf_set;
    logic              push_acc, pop_acc;

    assign req_ready = (state_q == StIdle) && !flush && !reset;
    assign push_acc  = req_valid && req_ready && (req_op == OP_PUSH);
    assign pop_acc   = req_valid && req_ready && (req_op == OP_POP);

    always_comb begin
        state_d         = state_q;
        sp_d            = sp_q;
        rsp_data_d      = rsp_data_q;
        rsp_err_d       = rsp_err_q;
        ovf_set         = 1'b0;
        unf_set         = 1'b0;
        stk_push_enable = 1'b0;
        stk_pop_enable  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    sp_d = '0;
                end else if (push_acc) begin
                    if (sp_q < DepthC) begin
                        stk_push_enable = 1'b1;
                        sp_d            = sp_q + OneC;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (pop_acc) begin
                    if (sp_q != '0) begin
                        stk_pop_enable = 1'b1;
                        sp_d           = sp_q - OneC;
                        state_d        = StPopWait;
                    end else begin
                        // Underflow answers immediately with a zero word flagged as error.
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        unf_set    = 1'b1;
                        state_d    = StResp;
                    end
                end
            end
            StPopWait: begin
                rsp_data_d = stk_data_out;
                rsp_err_d  = 1'b0;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new error wins over a same-cycle clear.
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        unf_d = unf_set | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sp_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign rsp_valid       = (state_q == StResp);
    assign rsp_data        = rsp_data_q;
    assign rsp_err         = rsp_err_q;
    assign full            = (sp_q == DepthC);
    assign empty           = (sp_q == '0);
    assign err_overflow    = ovf_q;
    assign err_underflow   = unf_q;
    assign stk_read_enable = 1'b0;
    assign stk_sp_in       = {{(32 - CNT_W){1'b0}}, sp_q};
    assign stk_data_in     = req_data;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl with a behavioural stack RAM alongside.
module tb_stack_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned CNT_W  = 7;

    logic              clk = 1'b0;
    logic              reset, req_valid, req_op, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic              flush, clr_err, full, empty, err_overflow, err_underflow;
    logic              stk_push_enable, stk_pop_enable, stk_read_enable;
    logic [DATA_W-1:0] req_data, rsp_data, stk_data_in, stk_data_out;
    logic [31:0]       stk_sp_in;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q = '0;

    always #5 clk = ~clk;

    stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .flush           (flush),
        .clr_err         (clr_err),
        .full            (full),
        .empty           (empty),
        .err_overflow    (err_overflow),
        .err_underflow   (err_underflow),
        .stk_push_enable (stk_push_enable),
        .stk_pop_enable  (stk_pop_enable),
        .stk_read_enable (stk_read_enable),
        .stk_sp_in       (stk_sp_in),
        .stk_data_in     (stk_data_in),
        .stk_data_out    (stk_data_out)
    );

    // Stack RAM model: push writes at sp, pop returns the word at sp-1 one cycle later.
    always_ff @(posedge clk) begin
        if (stk_push_enable) mem[stk_sp_in[5:0]] <= stk_data_in;
        if (stk_pop_enable) ram_q <= mem[stk_sp_in[5:0] - 6'd1];
    end
    assign stk_data_out = ram_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (stk_push_enable && stk_pop_enable) begin
            chk("push_pop_exclusive", 64'd1, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d, input logic exp_en);
        req_valid = 1'b1; req_op = 1'b0; req_data = d;
        settle();
        chk("push_ready", 64'(req_ready), 64'd1);
        chk("push_en", 64'(stk_push_enable), 64'(exp_en));
        if (exp_en) chk("push_data_in", 64'(stk_data_in), 64'(d));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_pop(input string tag, input logic [DATA_W-1:0] exp_d, input logic exp_err);
        req_valid = 1'b1; req_op = 1'b1;
        settle();
        chk({tag, "_pop_en"}, 64'(stk_pop_enable), 64'(!exp_err));
        tick();
        req_valid = 1'b0;
        if (!exp_err) begin
            settle();
            chk({tag, "_wait_valid"}, 64'(rsp_valid), 64'd0);
            tick();
        end
        settle();
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_d));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(exp_err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b1; req_op = 1'b0; req_data = 32'h1;
        rsp_ready = 1'b0; flush = 1'b0; clr_err = 1'b0;
        tick();
        settle();
        chk("reset_push_en", 64'(stk_push_enable), 64'd0);
        chk("reset_read_en", 64'(stk_read_enable), 64'd0);
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        settle();
        chk("reset_sp", 64'(stk_sp_in), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_errs", 64'({err_overflow, err_underflow}), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'd1);

        // LIFO order
        do_push(32'hA, 1'b1);
        do_push(32'hB, 1'b1);
        do_push(32'hC, 1'b1);
        chk("lifo_sp3", 64'(stk_sp_in), 64'd3);
        do_pop("lifo_c", 32'hC, 1'b0);
        do_pop("lifo_b", 32'hB, 1'b0);
        do_pop("lifo_a", 32'hA, 1'b0);
        settle();
        chk("lifo_sp0", 64'(stk_sp_in), 64'd0);
        chk("lifo_empty", 64'(empty), 64'd1);

        // Overflow
        for (int i = 0; i < 64; i++) do_push(DATA_W'(32'h100 + i), 1'b1);
        settle();
        chk("ovf_full", 64'(full), 64'd1);
        chk("ovf_sp64", 64'(stk_sp_in), 64'd64);
        do_push(32'hDEAD, 1'b0);
        settle();
        chk("ovf_flag", 64'(err_overflow), 64'd1);
        chk("ovf_sp_hold", 64'(stk_sp_in), 64'd64);
        chk("ovf_full_hold", 64'(full), 64'd1);
        do_pop("ovf_top", 32'h13F, 1'b0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        settle();
        chk("ovf_clr", 64'(err_overflow), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        chk("flush_sp0", 64'(stk_sp_in), 64'd0);

        // Underflow, then clear, then clear colliding with a new error
        do_pop("unf", 32'h0, 1'b1);
        settle();
        chk("unf_flag", 64'(err_underflow), 64'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        settle();
        chk("unf_clr", 64'(err_underflow), 64'd0);
        req_valid = 1'b1; req_op = 1'b1; clr_err = 1'b1;
        tick();
        req_valid = 1'b0; clr_err = 1'b0;
        settle();
        chk("unf_clr_collide", 64'(err_underflow), 64'd1);
        chk("unf_clr_collide_rsp", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Response backpressure with flush asserted (ignored outside IDLE)
        do_push(32'h11, 1'b1);
        do_push(32'h55, 1'b1);
        req_valid = 1'b1; req_op = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_data", 64'(rsp_data), 64'h55);
            chk("bp_ready_low", 64'(req_ready), 64'd0);
            tick();
        end
        settle();
        chk("bp_flush_ignored", 64'(stk_sp_in), 64'd1);
        flush = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        do_pop("bp_rest", 32'h11, 1'b0);

        // Flush overrides a simultaneous push
        do_push(32'h1, 1'b1);
        do_push(32'h2, 1'b1);
        do_push(32'h3, 1'b1);
        req_valid = 1'b1; req_op = 1'b0; req_data = 32'h4; flush = 1'b1;
        settle();
        chk("flush_not_ready", 64'(req_ready), 64'd0);
        chk("flush_no_push", 64'(stk_push_enable), 64'd0);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        settle();
        chk("flush_req_sp0", 64'(stk_sp_in), 64'd0);

        // Reset during POP_WAIT discards the response
        do_push(32'h77, 1'b1);
        req_valid = 1'b1; req_op = 1'b1;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rst_pw_valid", 64'(rsp_valid), 64'd0);
        chk("rst_pw_sp", 64'(stk_sp_in), 64'd0);
        chk("rst_pw_ready", 64'(req_ready), 64'd1);
        tick();
        settle();
        chk("rst_pw_valid_later", 64'(rsp_valid), 64'd0);
        chk("rst_pw_data", 64'(rsp_data), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
